// File: rtl/vanilla_exe_bubble_classifier_pkg.sv
// Types shared by the EXE bubble classifier: bubble causes, long-op
// scoreboard classes and the pipeline register views it inspects.
package vanilla_exe_bubble_classifier_pkg;

    localparam int RV32_reg_addr_width_gp = 5;
    localparam int RV32_Iimm_width_gp     = 12;
    localparam int sb_entries_lp          = 32;

    typedef enum logic [31:0] {
        e_exe_no_bubble,
        e_exe_bubble_branch_miss,
        e_exe_bubble_jalr_miss,
        e_exe_bubble_icache_miss,
        e_exe_bubble_stall_depend_dram,
        e_exe_bubble_stall_depend_global,
        e_exe_bubble_stall_depend_group,
        e_exe_bubble_stall_depend_fdiv,
        e_exe_bubble_stall_depend_idiv,
        e_exe_bubble_stall_depend_local_load,
        e_exe_bubble_stall_depend_imul,
        e_exe_bubble_stall_amo_aq,
        e_exe_bubble_stall_amo_rl,
        e_exe_bubble_stall_bypass,
        e_exe_bubble_stall_lr_aq,
        e_exe_bubble_stall_fence,
        e_exe_bubble_stall_remote_req,
        e_exe_bubble_stall_remote_credit,
        e_exe_bubble_stall_fdiv_busy,
        e_exe_bubble_stall_idiv_busy,
        e_exe_bubble_stall_fcsr,
        e_exe_bubble_stall_barrier
    } exe_bubble_type_e;

    typedef enum logic [2:0] {
        e_sb_none,
        e_sb_dram,
        e_sb_global,
        e_sb_group,
        e_sb_idiv,
        e_sb_fdiv
    } sb_class_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        logic [4:0] rd;
        logic       read_rs1;
        logic       read_rs2;
        logic       read_frs1;
        logic       read_frs2;
        logic       read_frs3;
        logic       write_rd;
        logic       write_frd;
    } id_signals_s;

    typedef struct packed {
        logic [4:0] rd;
        logic       is_load;
        logic       is_amo;
        logic       is_idiv;
        logic       write_frd;
    } exe_signals_s;

    typedef struct packed {
        logic [4:0] rd;
        logic       is_fdiv;
        logic       is_fsqrt;
    } fp_exe_ctrl_s;

    function automatic sb_class_e addr_class(input logic [31:0] addr);
        if (addr[31]) return e_sb_dram;
        else if (addr[30]) return e_sb_global;
        else if (addr[29]) return e_sb_group;
        else return e_sb_none;
    endfunction

    // dram > global > group > fdiv > idiv
    function automatic logic [2:0] sb_rank(input sb_class_e c);
        case (c)
            e_sb_dram:   return 3'd5;
            e_sb_global: return 3'd4;
            e_sb_group:  return 3'd3;
            e_sb_fdiv:   return 3'd2;
            e_sb_idiv:   return 3'd1;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic sb_class_e sb_max(input sb_class_e a, input sb_class_e b);
        return (sb_rank(b) > sb_rank(a)) ? b : a;
    endfunction

endpackage

// File: rtl/vanilla_exe_bubble_classifier.sv
// Classifies the EXE stage each cycle as a real instruction or a bubble,
// with the bubble cause and the word PC of the instruction responsible.
module vanilla_exe_bubble_classifier
    import vanilla_exe_bubble_classifier_pkg::*;
#(
    parameter int pc_width_p      = 30,
    parameter int data_width_p    = 32,
    parameter int x_cord_width_p  = 6,
    parameter int y_cord_width_p  = 5,
    parameter int origin_x_cord_p = 0,
    parameter int origin_y_cord_p = 0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [pc_width_p-1:0]             pc_r,
    input  logic [pc_width_p-1:0]             pc_n,
    input  logic [data_width_p-1:0]           if_pc,
    input  logic [data_width_p-1:0]           id_pc,
    input  logic [data_width_p-1:0]           exe_pc,
    input  logic                              flush,
    input  logic                              icache_miss,
    input  logic                              icache_miss_in_pipe,
    input  logic                              stall_all,
    input  logic                              stall_id,
    input  logic                              stall_depend_long_op,
    input  logic                              stall_depend_local_load,
    input  logic                              stall_depend_imul,
    input  logic                              stall_bypass,
    input  logic                              stall_lr_aq,
    input  logic                              stall_fence,
    input  logic                              stall_amo_aq,
    input  logic                              stall_amo_rl,
    input  logic                              stall_fdiv_busy,
    input  logic                              stall_idiv_busy,
    input  logic                              stall_fcsr,
    input  logic                              stall_remote_req,
    input  logic                              stall_remote_credit,
    input  logic                              stall_barrier,
    input  logic                              stall_icache_store,
    input  logic                              stall_remote_ld_wb,
    input  logic                              stall_ifetch_wait,
    input  logic                              stall_remote_flw_wb,
    input  logic                              branch_mispredict,
    input  logic                              jalr_mispredict,
    input  logic [data_width_p-1:0]           rs1_val_to_exe,
    input  logic [RV32_Iimm_width_gp-1:0]     mem_addr_op2,
    input  logic                              int_sb_clear,
    input  logic                              float_sb_clear,
    input  logic [RV32_reg_addr_width_gp-1:0] int_sb_clear_id,
    input  logic [RV32_reg_addr_width_gp-1:0] float_sb_clear_id,
    input  id_signals_s                       id_r,
    input  exe_signals_s                      exe_r,
    input  fp_exe_ctrl_s                      fp_exe_ctrl_r,
    input  logic [x_cord_width_p-1:0]         global_x_i,
    input  logic [y_cord_width_p-1:0]         global_y_i,
    output exe_bubble_type_e                  exe_bubble_type_o,
    output logic [pc_width_p-1:0]             exe_bubble_pc_o
);

    localparam int unused_origin_lp = origin_x_cord_p + origin_y_cord_p;

    exe_bubble_type_e        id_type_r, id_type_n;
    exe_bubble_type_e        exe_type_r, exe_type_n;
    logic [pc_width_p-1:0]   id_bpc_r, id_bpc_n;
    logic [pc_width_p-1:0]   exe_bpc_r, exe_bpc_n;
    exe_bubble_type_e        stall_type;
    exe_bubble_type_e        long_type;
    sb_class_e               long_class;
    sb_class_e               mem_class;
    sb_class_e               int_sb_r [sb_entries_lp];
    sb_class_e               flt_sb_r [sb_entries_lp];
    logic [31:0]             mem_addr;
    logic                    mem_op;
    logic                    int_mem_set;
    logic                    flt_mem_set;
    logic                    int_div_set;
    logic                    flt_div_set;
    logic [pc_width_p-1:0]   id_wpc;
    logic [pc_width_p-1:0]   exe_wpc;

    logic unused_sig;
    assign unused_sig = ^{pc_n, if_pc, flush, stall_icache_store,
                          stall_remote_ld_wb, stall_ifetch_wait,
                          stall_remote_flw_wb, global_x_i, global_y_i,
                          id_pc, exe_pc, rs1_val_to_exe};

    assign id_wpc  = id_pc[pc_width_p+1:2];
    assign exe_wpc = exe_pc[pc_width_p+1:2];

    assign mem_addr = rs1_val_to_exe[31:0]
                    + {{(32-RV32_Iimm_width_gp){mem_addr_op2[RV32_Iimm_width_gp-1]}},
                       mem_addr_op2};
    assign mem_class   = addr_class(mem_addr);
    assign mem_op      = exe_r.is_load | exe_r.is_amo;
    assign int_mem_set = mem_op & ~exe_r.write_frd
                       & (mem_class != e_sb_none) & (exe_r.rd != '0);
    assign flt_mem_set = mem_op & exe_r.write_frd & (mem_class != e_sb_none);
    assign int_div_set = exe_r.is_idiv & ~mem_op & (exe_r.rd != '0);
    assign flt_div_set = fp_exe_ctrl_r.is_fdiv | fp_exe_ctrl_r.is_fsqrt;

    // Worst outstanding long op among the registers the ID instruction touches
    always_comb begin
        long_class = e_sb_none;
        if (id_r.read_rs1)  long_class = sb_max(long_class, int_sb_r[id_r.rs1]);
        if (id_r.read_rs2)  long_class = sb_max(long_class, int_sb_r[id_r.rs2]);
        if (id_r.write_rd)  long_class = sb_max(long_class, int_sb_r[id_r.rd]);
        if (id_r.read_frs1) long_class = sb_max(long_class, flt_sb_r[id_r.rs1]);
        if (id_r.read_frs2) long_class = sb_max(long_class, flt_sb_r[id_r.rs2]);
        if (id_r.read_frs3) long_class = sb_max(long_class, flt_sb_r[id_r.rs3]);
        if (id_r.write_frd) long_class = sb_max(long_class, flt_sb_r[id_r.rd]);
    end

    always_comb begin
        case (long_class)
            e_sb_global: long_type = e_exe_bubble_stall_depend_global;
            e_sb_group:  long_type = e_exe_bubble_stall_depend_group;
            e_sb_fdiv:   long_type = e_exe_bubble_stall_depend_fdiv;
            e_sb_idiv:   long_type = e_exe_bubble_stall_depend_idiv;
            default:     long_type = e_exe_bubble_stall_depend_dram;
        endcase
    end

    // Several causes may be raised together; the order below decides
    always_comb begin
        stall_type = e_exe_no_bubble;
        if (stall_depend_long_op)         stall_type = long_type;
        else if (stall_depend_local_load) stall_type = e_exe_bubble_stall_depend_local_load;
        else if (stall_depend_imul)       stall_type = e_exe_bubble_stall_depend_imul;
        else if (stall_bypass)            stall_type = e_exe_bubble_stall_bypass;
        else if (stall_lr_aq)             stall_type = e_exe_bubble_stall_lr_aq;
        else if (stall_fence)             stall_type = e_exe_bubble_stall_fence;
        else if (stall_amo_aq)            stall_type = e_exe_bubble_stall_amo_aq;
        else if (stall_amo_rl)            stall_type = e_exe_bubble_stall_amo_rl;
        else if (stall_remote_req)        stall_type = e_exe_bubble_stall_remote_req;
        else if (stall_remote_credit)     stall_type = e_exe_bubble_stall_remote_credit;
        else if (stall_fdiv_busy)         stall_type = e_exe_bubble_stall_fdiv_busy;
        else if (stall_idiv_busy)         stall_type = e_exe_bubble_stall_idiv_busy;
        else if (stall_fcsr)              stall_type = e_exe_bubble_stall_fcsr;
        else if (stall_barrier)           stall_type = e_exe_bubble_stall_barrier;
    end

    always_comb begin
        exe_type_n = id_type_r;
        exe_bpc_n  = id_bpc_r;
        id_type_n  = e_exe_no_bubble;
        id_bpc_n   = '0;
        if (branch_mispredict) begin
            exe_type_n = e_exe_bubble_branch_miss;
            exe_bpc_n  = exe_wpc;
        end else if (jalr_mispredict) begin
            exe_type_n = e_exe_bubble_jalr_miss;
            exe_bpc_n  = exe_wpc;
        end else if (stall_id) begin
            exe_type_n = stall_type;
            exe_bpc_n  = id_wpc;
        end
        if (branch_mispredict | jalr_mispredict) begin
            id_type_n = exe_type_n;
            id_bpc_n  = exe_wpc;
        end else if (stall_id) begin
            id_type_n = id_type_r;
            id_bpc_n  = id_bpc_r;
        end else if (icache_miss | icache_miss_in_pipe) begin
            id_type_n = e_exe_bubble_icache_miss;
            id_bpc_n  = pc_r;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            id_type_r  <= e_exe_no_bubble;
            id_bpc_r   <= '0;
            exe_type_r <= e_exe_no_bubble;
            exe_bpc_r  <= '0;
        end else if (!stall_all) begin
            id_type_r  <= id_type_n;
            id_bpc_r   <= id_bpc_n;
            exe_type_r <= exe_type_n;
            exe_bpc_r  <= exe_bpc_n;
        end
    end

    // Clears apply even under stall_all; a same-cycle set overrides a clear
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < sb_entries_lp; i++) begin
                int_sb_r[i] <= e_sb_none;
                flt_sb_r[i] <= e_sb_none;
            end
        end else begin
            for (int i = 0; i < sb_entries_lp; i++) begin
                if (int_sb_clear && int_sb_clear_id == 5'(i))
                    int_sb_r[i] <= e_sb_none;
                if (float_sb_clear && float_sb_clear_id == 5'(i))
                    flt_sb_r[i] <= e_sb_none;
                if (!stall_all) begin
                    if (int_mem_set && exe_r.rd == 5'(i))
                        int_sb_r[i] <= mem_class;
                    if (int_div_set && exe_r.rd == 5'(i))
                        int_sb_r[i] <= e_sb_idiv;
                    if (flt_div_set && fp_exe_ctrl_r.rd == 5'(i))
                        flt_sb_r[i] <= e_sb_fdiv;
                    if (flt_mem_set && exe_r.rd == 5'(i))
                        flt_sb_r[i] <= mem_class;
                end
            end
        end
    end

    assign exe_bubble_type_o = exe_type_r;
    assign exe_bubble_pc_o   = exe_bpc_r;

endmodule

// File: tb/tb_vanilla_exe_bubble_classifier.sv
// Scoreboard bench for the EXE bubble classifier: directed scenarios then
// random traffic, all checked against a cycle-level behavioural model.
module tb_vanilla_exe_bubble_classifier;
    import vanilla_exe_bubble_classifier_pkg::*;

    localparam int PCW = 30;
    localparam int DW  = 32;

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [PCW-1:0] pc_r, pc_n;
    logic [DW-1:0]  if_pc, id_pc, exe_pc, rs1_val_to_exe;
    logic           flush, icache_miss, icache_miss_in_pipe;
    logic           stall_all, stall_id;
    logic [13:0]    cause;
    logic [3:0]     ign;
    logic           branch_mispredict, jalr_mispredict;
    logic [11:0]    mem_addr_op2;
    logic           int_sb_clear, float_sb_clear;
    logic [4:0]     int_sb_clear_id, float_sb_clear_id;
    id_signals_s    id_r;
    exe_signals_s   exe_r;
    fp_exe_ctrl_s   fp_exe_ctrl_r;
    logic [5:0]     global_x_i;
    logic [4:0]     global_y_i;
    exe_bubble_type_e exe_bubble_type_o;
    logic [PCW-1:0] exe_bubble_pc_o;

    vanilla_exe_bubble_classifier dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pc_r(pc_r), .pc_n(pc_n),
        .if_pc(if_pc), .id_pc(id_pc), .exe_pc(exe_pc),
        .flush(flush), .icache_miss(icache_miss),
        .icache_miss_in_pipe(icache_miss_in_pipe),
        .stall_all(stall_all), .stall_id(stall_id),
        .stall_depend_long_op(cause[0]),
        .stall_depend_local_load(cause[1]),
        .stall_depend_imul(cause[2]),
        .stall_bypass(cause[3]),
        .stall_lr_aq(cause[4]),
        .stall_fence(cause[5]),
        .stall_amo_aq(cause[6]),
        .stall_amo_rl(cause[7]),
        .stall_remote_req(cause[8]),
        .stall_remote_credit(cause[9]),
        .stall_fdiv_busy(cause[10]),
        .stall_idiv_busy(cause[11]),
        .stall_fcsr(cause[12]),
        .stall_barrier(cause[13]),
        .stall_icache_store(ign[0]),
        .stall_remote_ld_wb(ign[1]),
        .stall_ifetch_wait(ign[2]),
        .stall_remote_flw_wb(ign[3]),
        .branch_mispredict(branch_mispredict),
        .jalr_mispredict(jalr_mispredict),
        .rs1_val_to_exe(rs1_val_to_exe),
        .mem_addr_op2(mem_addr_op2),
        .int_sb_clear(int_sb_clear), .float_sb_clear(float_sb_clear),
        .int_sb_clear_id(int_sb_clear_id),
        .float_sb_clear_id(float_sb_clear_id),
        .id_r(id_r), .exe_r(exe_r), .fp_exe_ctrl_r(fp_exe_ctrl_r),
        .global_x_i(global_x_i), .global_y_i(global_y_i),
        .exe_bubble_type_o(exe_bubble_type_o),
        .exe_bubble_pc_o(exe_bubble_pc_o)
    );

    // cause bit i -> reported type (bit 0 is refined by the long-op lookup)
    exe_bubble_type_e cause_t [14] = '{
        e_exe_bubble_stall_depend_dram, e_exe_bubble_stall_depend_local_load,
        e_exe_bubble_stall_depend_imul, e_exe_bubble_stall_bypass,
        e_exe_bubble_stall_lr_aq, e_exe_bubble_stall_fence,
        e_exe_bubble_stall_amo_aq, e_exe_bubble_stall_amo_rl,
        e_exe_bubble_stall_remote_req, e_exe_bubble_stall_remote_credit,
        e_exe_bubble_stall_fdiv_busy, e_exe_bubble_stall_idiv_busy,
        e_exe_bubble_stall_fcsr, e_exe_bubble_stall_barrier};

    // model table entries hold a severity: 0 none,1 idiv,2 fdiv,3 group,4 global,5 dram
    exe_bubble_type_e rank_t [6] = '{
        e_exe_bubble_stall_depend_dram, e_exe_bubble_stall_depend_idiv,
        e_exe_bubble_stall_depend_fdiv, e_exe_bubble_stall_depend_group,
        e_exe_bubble_stall_depend_global, e_exe_bubble_stall_depend_dram};

    exe_bubble_type_e m_id_t, m_ex_t;
    logic [PCW-1:0]   m_id_pc, m_ex_pc;
    int               m_int [32];
    int               m_flt [32];
    logic [61:0]      exp_q [$];
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    function automatic int mx(input int a, input int b);
        return (b > a) ? b : a;
    endfunction

    task automatic model_reset();
        m_id_t = e_exe_no_bubble;
        m_ex_t = e_exe_no_bubble;
        m_id_pc = '0;
        m_ex_pc = '0;
        for (int i = 0; i < 32; i++) begin
            m_int[i] = 0;
            m_flt[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] addr;
        int cls, best, c;
        exe_bubble_type_e nx_t, ni_t;
        logic [PCW-1:0] nx_pc, ni_pc;
        addr = rs1_val_to_exe + {{20{mem_addr_op2[11]}}, mem_addr_op2};
        cls = (addr >= 32'h8000_0000) ? 5 :
              (addr >= 32'h4000_0000) ? 4 :
              (addr >= 32'h2000_0000) ? 3 : 0;
        best = 0;
        if (id_r.read_rs1)  best = mx(best, m_int[id_r.rs1]);
        if (id_r.read_rs2)  best = mx(best, m_int[id_r.rs2]);
        if (id_r.write_rd)  best = mx(best, m_int[id_r.rd]);
        if (id_r.read_frs1) best = mx(best, m_flt[id_r.rs1]);
        if (id_r.read_frs2) best = mx(best, m_flt[id_r.rs2]);
        if (id_r.read_frs3) best = mx(best, m_flt[id_r.rs3]);
        if (id_r.write_frd) best = mx(best, m_flt[id_r.rd]);
        c = -1;
        for (int i = 13; i >= 0; i--) if (cause[i]) c = i;
        if (branch_mispredict || jalr_mispredict) begin
            nx_t = branch_mispredict ? e_exe_bubble_branch_miss
                                     : e_exe_bubble_jalr_miss;
            nx_pc = PCW'(exe_pc >> 2);
            ni_t = nx_t;
            ni_pc = nx_pc;
        end else if (stall_id) begin
            nx_t = (c < 0) ? e_exe_no_bubble :
                   (c == 0) ? rank_t[best] : cause_t[c];
            nx_pc = PCW'(id_pc >> 2);
            ni_t = m_id_t;
            ni_pc = m_id_pc;
        end else begin
            nx_t = m_id_t;
            nx_pc = m_id_pc;
            ni_t = (icache_miss || icache_miss_in_pipe)
                 ? e_exe_bubble_icache_miss : e_exe_no_bubble;
            ni_pc = (icache_miss || icache_miss_in_pipe) ? pc_r : '0;
        end
        if (int_sb_clear)   m_int[int_sb_clear_id] = 0;
        if (float_sb_clear) m_flt[float_sb_clear_id] = 0;
        if (!stall_all) begin
            m_id_t = ni_t; m_id_pc = ni_pc;
            m_ex_t = nx_t; m_ex_pc = nx_pc;
            if ((exe_r.is_load || exe_r.is_amo) && cls != 0) begin
                if (exe_r.write_frd) m_flt[exe_r.rd] = cls;
                else if (exe_r.rd != 0) m_int[exe_r.rd] = cls;
            end else if (exe_r.is_idiv && !exe_r.is_load && !exe_r.is_amo
                         && exe_r.rd != 0) begin
                m_int[exe_r.rd] = 1;
            end
            if (fp_exe_ctrl_r.is_fdiv || fp_exe_ctrl_r.is_fsqrt)
                m_flt[fp_exe_ctrl_r.rd] = 2;
        end
        exp_q.push_back({m_ex_t, m_ex_pc});
    endtask

    always @(posedge clk_i) begin
        logic [61:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", {exe_bubble_type_o, exe_bubble_pc_o}, e);
        end
    end

    task automatic idle_inputs();
        pc_r = '0; pc_n = '0; if_pc = '0; id_pc = '0; exe_pc = '0;
        rs1_val_to_exe = '0; mem_addr_op2 = '0;
        flush = 0; icache_miss = 0; icache_miss_in_pipe = 0;
        stall_all = 0; stall_id = 0; cause = '0; ign = '0;
        branch_mispredict = 0; jalr_mispredict = 0;
        int_sb_clear = 0; float_sb_clear = 0;
        int_sb_clear_id = '0; float_sb_clear_id = '0;
        id_r = '0; exe_r = '0; fp_exe_ctrl_r = '0;
        global_x_i = '0; global_y_i = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic random_inputs();
        logic [3:0] top;
        idle_inputs();
        pc_r = PCW'($urandom);
        pc_n = PCW'($urandom);
        id_pc = $urandom;
        exe_pc = $urandom;
        ign = 4'($urandom);
        flush = 1'($urandom);
        stall_all = ($urandom_range(0, 5) == 0);
        stall_id = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 14; i++) cause[i] = ($urandom_range(0, 4) == 0);
        branch_mispredict = ($urandom_range(0, 9) == 0);
        jalr_mispredict = ($urandom_range(0, 9) == 0);
        icache_miss = ($urandom_range(0, 5) == 0);
        icache_miss_in_pipe = ($urandom_range(0, 7) == 0);
        top = 4'($urandom);
        rs1_val_to_exe = {top, 28'($urandom)};
        mem_addr_op2 = 12'($urandom);
        case ($urandom_range(0, 3))
            1: exe_r.is_load = 1;
            2: exe_r.is_amo = 1;
            3: exe_r.is_idiv = 1;
            default: ;
        endcase
        exe_r.rd = 5'($urandom_range(0, 7));
        exe_r.write_frd = exe_r.is_load & 1'($urandom);
        fp_exe_ctrl_r.rd = 5'($urandom_range(8, 15));
        fp_exe_ctrl_r.is_fdiv = ($urandom_range(0, 3) == 0);
        fp_exe_ctrl_r.is_fsqrt = ($urandom_range(0, 7) == 0);
        int_sb_clear = ($urandom_range(0, 2) == 0);
        float_sb_clear = ($urandom_range(0, 2) == 0);
        int_sb_clear_id = 5'($urandom_range(0, 15));
        float_sb_clear_id = 5'($urandom_range(0, 15));
        id_r = id_signals_s'({$urandom, $urandom});
        id_r.rs1 = 5'($urandom_range(0, 15));
        id_r.rs2 = 5'($urandom_range(0, 15));
        id_r.rs3 = 5'($urandom_range(0, 15));
        id_r.rd = 5'($urandom_range(0, 15));
        global_x_i = 6'($urandom);
        global_y_i = 5'($urandom);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1;
        chk("reset_type", exe_bubble_type_o, e_exe_no_bubble);
        chk("reset_pc", exe_bubble_pc_o, 0);
        @(negedge clk_i);
        reset_i = 1;

        // mispredict: two bubbles with the branch PC
        exe_pc = 32'h1000;
        branch_mispredict = 1;
        step();
        chk("mis1_type", exe_bubble_type_o, e_exe_bubble_branch_miss);
        chk("mis1_pc", exe_bubble_pc_o, 30'h400);
        idle_inputs();
        step();
        chk("mis2_type", exe_bubble_type_o, e_exe_bubble_branch_miss);
        chk("mis2_pc", exe_bubble_pc_o, 30'h400);

        // asynchronous reset in the middle of a cycle
        #1;
        reset_i = 0;
        #1;
        chk("areset_type", exe_bubble_type_o, e_exe_no_bubble);
        chk("areset_pc", exe_bubble_pc_o, 0);
        model_reset();
        #2;
        reset_i = 1;

        // ID stall, then held by stall_all
        stall_id = 1;
        cause[5] = 1;
        id_pc = 32'h2004;
        step();
        chk("fence_type", exe_bubble_type_o, e_exe_bubble_stall_fence);
        chk("fence_pc", exe_bubble_pc_o, 30'h801);
        stall_all = 1;
        cause = 14'b1000;
        id_pc = 32'h3000;
        step();
        chk("hold_type", exe_bubble_type_o, e_exe_bubble_stall_fence);
        chk("hold_pc", exe_bubble_pc_o, 30'h801);

        // dram load into x5, global load into x6
        idle_inputs();
        exe_r.is_load = 1; exe_r.rd = 5;
        rs1_val_to_exe = 32'h8000_0000; mem_addr_op2 = 12'h010;
        step();
        exe_r.rd = 6; rs1_val_to_exe = 32'h4000_0020; mem_addr_op2 = 12'hFF0;
        step();
        idle_inputs();
        stall_id = 1; cause[0] = 1; id_pc = 32'h4000;
        id_r.read_rs1 = 1; id_r.rs1 = 5;
        step();
        chk("dram_type", exe_bubble_type_o, e_exe_bubble_stall_depend_dram);
        chk("dram_pc", exe_bubble_pc_o, 30'h1000);
        id_r.read_rs2 = 1; id_r.rs2 = 6;
        step();
        chk("global_type", exe_bubble_pc_o == 30'h1000 ?
            exe_bubble_type_o : 32'hdead, e_exe_bubble_stall_depend_dram);
        id_r.read_rs1 = 0;
        step();
        chk("global_only", exe_bubble_type_o, e_exe_bubble_stall_depend_global);
        idle_inputs();
        int_sb_clear = 1; int_sb_clear_id = 6;
        step();
        idle_inputs();
        stall_id = 1; cause[0] = 1; id_pc = 32'h4000;
        id_r.read_rs2 = 1; id_r.rs2 = 6;
        step();
        chk("cleared_default", exe_bubble_type_o, e_exe_bubble_stall_depend_dram);

        // group load into f3
        idle_inputs();
        exe_r.is_load = 1; exe_r.write_frd = 1; exe_r.rd = 3;
        rs1_val_to_exe = 32'h2000_0000;
        step();
        idle_inputs();
        stall_id = 1; cause[0] = 1; id_r.read_frs1 = 1; id_r.rs1 = 3;
        step();
        chk("group_type", exe_bubble_type_o, e_exe_bubble_stall_depend_group);

        // icache miss reaches EXE one cycle after entering ID
        idle_inputs();
        icache_miss = 1; pc_r = 30'h123;
        step();
        idle_inputs();
        step();
        chk("icache_type", exe_bubble_type_o, e_exe_bubble_icache_miss);
        chk("icache_pc", exe_bubble_pc_o, 30'h123);

        for (int n = 0; n < 400; n++) begin
            random_inputs();
            step();
        end
        idle_inputs();
        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
